// File: rtl/wb_pipe_reg_pkg.sv
// Shared constants, FSM encoding and entry layout for the MEM->WB register.
// Optional forwarding lookup is enabled with WB_PIPE_FWD_EN.
package wb_pipe_reg_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        Stop       = 1'b1;
    localparam logic        NoStop     = 1'b0;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_pipe_reg_if.sv
// MEM->WB writeback bus: input handshake, output handshake, optional
// forwarding lookup (WB_PIPE_FWD_EN).
interface wb_pipe_reg_if #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NUM_CH = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_CH*AW-1:0] in_wd;
    logic [NUM_CH-1:0]    in_wreg;
    logic [NUM_CH*DW-1:0] in_wdata;
    logic                 out_ready;
    logic                 out_valid;
    logic [NUM_CH*AW-1:0] out_wd;
    logic [NUM_CH-1:0]    out_wreg;
    logic [NUM_CH*DW-1:0] out_wdata;
`ifdef WB_PIPE_FWD_EN
    logic [AW-1:0]        fwd_addr;
    logic                 fwd_hit;
    logic [DW-1:0]        fwd_data;
`endif

    modport master (
        output in_valid, in_wd, in_wreg, in_wdata, out_ready,
`ifdef WB_PIPE_FWD_EN
        output fwd_addr,
        input  fwd_hit, fwd_data,
`endif
        input  in_ready, out_valid, out_wd, out_wreg, out_wdata
    );

    modport slave (
        input  in_valid, in_wd, in_wreg, in_wdata, out_ready,
`ifdef WB_PIPE_FWD_EN
        input  fwd_addr,
        output fwd_hit, fwd_data,
`endif
        output in_ready, out_valid, out_wd, out_wreg, out_wdata
    );

endinterface

// File: rtl/wb_entry_sanitize.sv
// Masks writes to x0 and resolves same-address collisions within one entry;
// the higher channel keeps its write.
module wb_entry_sanitize #(
    parameter int AW     = 5,
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0][AW-1:0] wd,
    input  logic [NUM_CH-1:0]         wreg,
    output logic [NUM_CH-1:0]         wreg_o
);

    always_comb begin
        wreg_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wreg_o[i] = wreg[i] && (wd[i] != '0);
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (wreg[j] && (wd[j] == wd[i]))
                    wreg_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with 2-entry skid buffer, flush and stall vector.
// Define WB_PIPE_FWD_EN to add the combinational forwarding lookup.
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int NUM_CH    = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    wb_pipe_reg_if.slave       bus
);

    typedef struct packed {
        logic [NUM_CH-1:0][AW-1:0] wd;
        logic [NUM_CH-1:0]         wreg;
        logic [NUM_CH-1:0][DW-1:0] wdata;
    } entry_t;

    wb_state_e         state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    entry_t            in_ent;
    logic              in_ready_q, in_ready_d;
    logic [NUM_CH-1:0] in_wreg_s;
    logic              acc, pop, out_vld;
    logic              unused_stall;

    assign unused_stall = ^stall;

    wb_entry_sanitize #(
        .AW     (AW),
        .NUM_CH (NUM_CH)
    ) u_sanitize (
        .wd     (bus.in_wd),
        .wreg   (bus.in_wreg),
        .wreg_o (in_wreg_s)
    );

    always_comb begin
        in_ent.wd    = bus.in_wd;
        in_ent.wreg  = in_wreg_s;
        in_ent.wdata = bus.in_wdata;
    end

    assign out_vld = (state_q != EMPTY);
    assign acc = bus.in_valid && in_ready_q && (stall[STAGE_IDX] != Stop);
    assign pop = out_vld && bus.out_ready && (stall[STAGE_IDX+1] != Stop);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else if (rdy) begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        head_d  = in_ent;
                    end
                end
                FULL: begin
                    if (acc && pop) begin
                        head_d  = in_ent;
                    end else if (acc) begin
                        state_d = SKID;
                        skid_d  = in_ent;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state_d = FULL;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Stale head contents are masked so an empty stage reads as a NOP.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_vld;
    assign bus.out_wd    = out_vld ? head_q.wd : '0;
    assign bus.out_wreg  = out_vld ? head_q.wreg : '0;
    assign bus.out_wdata = out_vld ? head_q.wdata : '0;

`ifdef WB_PIPE_FWD_EN
    // Skid is younger than head, so it is searched last and overrides.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        if (bus.fwd_addr != '0) begin
            if (out_vld) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (head_q.wreg[c] && head_q.wd[c] == bus.fwd_addr) begin
                        bus.fwd_hit  = 1'b1;
                        bus.fwd_data = head_q.wdata[c];
                    end
                end
            end
            if (state_q == SKID) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (skid_q.wreg[c] && skid_q.wd[c] == bus.fwd_addr) begin
                        bus.fwd_hit  = 1'b1;
                        bus.fwd_data = skid_q.wdata[c];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed vector bench for wb_pipe_reg (2 channels, 5-bit addr, 32-bit data).
// Forwarding checks are compiled in with WB_PIPE_FWD_EN.
module tb_wb_pipe_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [5:0] stall;
    logic       flush;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    wb_pipe_reg_if #(.AW(5), .DW(32), .NUM_CH(2)) bus ();

    wb_pipe_reg #(
        .AW(5), .DW(32), .NUM_CH(2), .STALL_W(6), .STAGE_IDX(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic        iv, en, fl, ordy;
        logic [5:0]  stl;
        logic [4:0]  wd0, wd1;
        logic [1:0]  wreg;
        logic [31:0] d0, d1;
        logic        ev, eir;
        logic [4:0]  ewd0, ewd1;
        logic [1:0]  ewreg;
        logic [31:0] ed0, ed1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic iv, logic en, logic fl, logic ordy, logic [5:0] stl,
        logic [4:0] wd0, logic [4:0] wd1, logic [1:0] wreg,
        logic [31:0] d0, logic [31:0] d1,
        logic ev, logic eir, logic [4:0] ewd0, logic [4:0] ewd1,
        logic [1:0] ewreg, logic [31:0] ed0, logic [31:0] ed1);
        vec_t v;
        v.iv = iv; v.en = en; v.fl = fl; v.ordy = ordy; v.stl = stl;
        v.wd0 = wd0; v.wd1 = wd1; v.wreg = wreg; v.d0 = d0; v.d1 = d1;
        v.ev = ev; v.eir = eir; v.ewd0 = ewd0; v.ewd1 = ewd1;
        v.ewreg = ewreg; v.ed0 = ed0; v.ed1 = ed1;
        return v;
    endfunction

    function automatic logic [77:0] snap();
        return {bus.out_valid, bus.in_ready, bus.out_wd,
                bus.out_wreg, bus.out_wdata};
    endfunction

    task automatic chk(string name, logic [77:0] got, logic [77:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    localparam logic [77:0] IDLE = {1'b0, 1'b1, 76'd0};

    initial begin
        rst = 1'b1; rdy = 1'b1; stall = '0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_wd = '0; bus.in_wreg = '0;
        bus.in_wdata = '0; bus.out_ready = 1'b0;
`ifdef WB_PIPE_FWD_EN
        bus.fwd_addr = '0;
`endif
        // iv en fl ordy stall | wd0 wd1 wreg d0 d1 | ev eir ewd0 ewd1 ewreg ed0 ed1
        vecs.push_back(mk(1,1,0,1,6'h00, 5,0,2'b01,32'hDEADBEEF,0, 1,1,5,0,2'b01,32'hDEADBEEF,0));
        vecs.push_back(mk(0,1,0,1,6'h00, 0,0,2'b00,0,0,           0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,0,0,6'h00, 7,7,2'b11,1,2,           1,1,7,7,2'b10,1,2));
        vecs.push_back(mk(1,1,0,0,6'h00, 0,3,2'b11,3,4,           1,0,7,7,2'b10,1,2));
        vecs.push_back(mk(1,1,0,0,6'h00, 8,0,2'b01,5,0,           1,0,7,7,2'b10,1,2));
        vecs.push_back(mk(0,1,0,1,6'h00, 0,0,2'b00,0,0,           1,1,0,3,2'b10,3,4));
        vecs.push_back(mk(0,1,0,1,6'h00, 0,0,2'b00,0,0,           0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,0,1,6'h00, 10,0,2'b01,32'hA,0,      1,1,10,0,2'b01,32'hA,0));
        vecs.push_back(mk(1,1,0,1,6'h08, 11,0,2'b01,32'hB,0,      0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,0,1,6'h00, 12,0,2'b01,32'hC,0,      1,1,12,0,2'b01,32'hC,0));
        vecs.push_back(mk(1,1,0,1,6'h18, 13,0,2'b01,32'hD,0,      1,1,12,0,2'b01,32'hC,0));
        vecs.push_back(mk(1,1,0,1,6'h18, 13,0,2'b01,32'hD,0,      1,1,12,0,2'b01,32'hC,0));
        vecs.push_back(mk(1,1,0,0,6'h00, 13,0,2'b01,32'hD,0,      1,0,12,0,2'b01,32'hC,0));
        vecs.push_back(mk(1,1,1,0,6'h00, 16,0,2'b01,32'h16,0,     0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,0,0,6'h00, 14,0,2'b01,32'hE,0,      1,1,14,0,2'b01,32'hE,0));
        vecs.push_back(mk(1,1,0,0,6'h00, 15,0,2'b01,32'hF,0,      1,0,14,0,2'b01,32'hE,0));
        vecs.push_back(mk(1,0,0,1,6'h00, 17,0,2'b01,32'h17,0,     1,0,14,0,2'b01,32'hE,0));
        vecs.push_back(mk(0,1,0,1,6'h00, 0,0,2'b00,0,0,           1,1,15,0,2'b01,32'hF,0));
        vecs.push_back(mk(0,1,0,1,6'h00, 0,0,2'b00,0,0,           0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,1,1,6'h00, 18,0,2'b01,32'h18,0,     0,1,0,0,2'b00,0,0));
        vecs.push_back(mk(1,1,0,0,6'h00, 0,9,2'b10,0,32'h11,      1,1,0,9,2'b10,0,32'h11));
        vecs.push_back(mk(1,1,0,0,6'h00, 9,0,2'b01,32'h22,0,      1,0,0,9,2'b10,0,32'h11));

        repeat (2) @(posedge clk);
        #1;
        chk("reset", snap(), IDLE);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_valid  = vecs[i].iv;
            rdy           = vecs[i].en;
            flush         = vecs[i].fl;
            bus.out_ready = vecs[i].ordy;
            stall         = vecs[i].stl;
            bus.in_wd     = {vecs[i].wd1, vecs[i].wd0};
            bus.in_wreg   = vecs[i].wreg;
            bus.in_wdata  = {vecs[i].d1, vecs[i].d0};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), snap(),
                {vecs[i].ev, vecs[i].eir, vecs[i].ewd1, vecs[i].ewd0,
                 vecs[i].ewreg, vecs[i].ed1, vecs[i].ed0});
        end

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        stall = '0;
        rdy = 1'b1;
        flush = 1'b0;
`ifdef WB_PIPE_FWD_EN
        bus.fwd_addr = 5'd9;
        #1;
        chk("fwd_skid_hit", {44'd0, bus.fwd_hit, bus.fwd_data},
            {44'd0, 1'b1, 32'h22});
        bus.fwd_addr = 5'd0;
        #1;
        chk("fwd_x0_miss", {44'd0, bus.fwd_hit, bus.fwd_data},
            {44'd0, 1'b0, 32'h0});
`endif
        // Flush while SKID with a new entry offered.
        bus.in_valid = 1'b1;
        bus.in_wd = {5'd0, 5'd20};
        bus.in_wreg = 2'b01;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_skid", snap(), IDLE);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_flush_idle", snap(), IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
- Parametrised MEM→WB pipeline register; successor to the single-channel MEM/WB latch.
- Carries NUM_CH parallel writeback channels (dual-issue ready) with a valid/ready handshake and a 2-entry skid buffer, so register-file back-pressure never drops a result.
- Keeps the legacy stall-vector semantics, and adds flush, x0 write suppression and same-address collision resolution.
- Sits between the MEM stage and the register file write port(s).

Parameters:
- AW, 5, register address width
- DW, 32, write data width
- NUM_CH, 2, writeback channels per entry (≥1)
- STALL_W, 6, stall vector width
- STAGE_IDX, 3, stall bit owned by MEM; STAGE_IDX+1 is WB (must be < STALL_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; 0 freezes all state
- stall  in  STALL_W  pipeline stall vector
- flush  in  1  discard all buffered entries
- in_valid  in  1  MEM entry valid
- in_ready  out  1  buffer can accept an entry (registered)
- in_wd  in  NUM_CH*AW  dest addresses, channel c at [c*AW +: AW]
- in_wreg  in  NUM_CH  write enables
- in_wdata  in  NUM_CH*DW  write data
- out_ready  in  1  register file accepts
- out_valid  out  1  head entry valid
- out_wd  out  NUM_CH*AW  head addresses
- out_wreg  out  NUM_CH  head write enables
- out_wdata  out  NUM_CH*DW  head data

Behaviour:
- Priority per cycle: rst > flush > !rdy (hold everything) > normal.
- Reset and flush: state EMPTY; out_valid=0, out_wd=0, out_wreg=0, out_wdata=0; skid cleared; in_ready=1 next cycle.
- Effective handshake:
  - acc = in_valid & in_ready & !stall[STAGE_IDX]
  - pop = out_valid & out_ready & !stall[STAGE_IDX+1]
- Capture sanitising, applied to each accepted entry:
  - channel with wd==0 gets wreg forced to 0;
  - if channels i<j both have wreg and equal wd, wreg[i] is forced to 0 (higher index wins);
  - data and address are stored unchanged.
- FSM, registered:
  - EMPTY
    - acc → FULL; head ← in.
  - FULL
    - acc & pop → FULL; head ← in.
    - acc & !pop → SKID; skid ← in.
    - !acc & pop → EMPTY.
    - else hold.
  - SKID
    - pop → FULL; head ← skid.
    - in_ready=0, so acc is impossible.
- in_ready = (state != SKID), registered, never combinational from out_ready.
- Outputs:
  - out_valid = (state != EMPTY).
  - When EMPTY, out_wreg=0, out_wd=0, out_wdata=0 (bubble), matching legacy NOP encoding.
- Legacy bubble:
  - stall[STAGE_IDX]=1 & stall[STAGE_IDX+1]=0 with state FULL and pop → EMPTY (bubble inserted).
  - stall[STAGE_IDX+1]=1 holds head regardless of out_ready.
- Latency: 1 cycle in→out when EMPTY; throughput 1 entry/cycle in steady state.
- Simultaneous flush and acc: flush wins, entry dropped.
- rdy low mid-SKID: everything holds, resume exactly.

Optional Feature:
- Macro WB_PIPE_FWD_EN.
- Defined:
  - adds ports fwd_addr (in, AW), fwd_hit (out, 1) and fwd_data (out, DW), all combinational.
  - Lookup searches the skid entry first (youngest), then the head; within an entry, the highest channel wins.
  - hit requires wreg=1 and fwd_addr≠0.
  - On miss, fwd_data=0.
- Undefined: ports absent, no lookup logic.

Decomposition:
- Shared package/defines: RstEnable, Stop/NoStop, NOPRegAddr, ZeroWord, the FSM state encoding (EMPTY=2'b00, FULL=2'b01, SKID=2'b10), and a packed wb_entry typedef {wd, wreg, wdata}.
- One sub-module, wb_entry_sanitize: combinational x0 and collision masking, instantiated once on the input path.

Test Plan:
- Reset → out_valid=0, out_wreg=0, in_ready=1; then acc ch0 {wd=5, data=0xDEADBEEF} → next cycle out_wd[4:0]=5, out_wreg=2'b01.
- out_ready=0 for 3 cycles while 2 entries are pushed → state SKID, in_ready=0; release → entries drain in order A then B, nothing lost.
- ch0 and ch1 both wd=7 with wreg=2'b11 → out_wreg=2'b10; ch0 wd=0 with wreg=1 → out_wreg[0]=0.
- stall=6'b001000 while FULL and popping → EMPTY bubble, out_wreg=0; stall=6'b011000 → head held 2 cycles even with out_ready=1.
- Flush asserted while SKID with in_valid=1 → next cycle EMPTY, in_ready=1, all outputs 0.
- With WB_PIPE_FWD_EN: head ch1 {wd=9, data=0x11}, skid ch0 {wd=9, data=0x22}, fwd_addr=9 → fwd_hit=1, fwd_data=0x22; fwd_addr=0 → fwd_hit=0.
